prbs_gen: RTL and testbench
===========================

# prbs_gen

Parametrised multi-polynomial PRBS generator, successor to the 7/9-bit `prng`. It produces `DATA_W` sequence bits per cycle from PRBS7, PRBS9, PRBS15, PRBS23 or PRBS31, selected at seed-load time. Output uses a valid/ready stream with back-pressure, and the block supports single-bit error injection and an accepted-word counter. It feeds the serializer/lane test path and pairs with the PRBS checker on the receive side.

## Interface
- `DATA_W`, default 32: bits per output word. Legal range 1..64.
- `CNT_W`, default 32: width of the accepted-word counter.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mode` in 3: polynomial select, sampled only on `seed_load`. Values: 0 = PRBS7 (x^7+x^6+1), 1 = PRBS9 (x^9+x^5+1), 2 = PRBS15 (x^15+x^14+1), 3 = PRBS23 (x^23+x^18+1), 4 = PRBS31 (x^31+x^28+1).
- `seed` in 31: initial LFSR state; only the low N bits are used.
- `seed_load` in 1: one-cycle pulse; latches `mode` and `seed`.
- `enable` in 1: permits generation of new words.
- `inj_err` in 1: pulse; inverts one bit of the next generated word.
- `out_valid` out 1: `out_data` holds a valid word.
- `out_ready` in 1: downstream accepts a word.
- `out_data` out `DATA_W`: sequence bits; the earliest bit is in the MSB.
- `mode_err` out 1: a reserved `mode` value (5..7) was latched.
- `word_cnt` out `CNT_W`: number of accepted words; wraps modulo 2^`CNT_W`.

## Operation
- State register `lfsr[30:0]`; the active length N and second tap M come from the latched mode.
- Per bit step: `b = lfsr[N-1] ^ lfsr[M-1]`; `lfsr <= {lfsr, b}` masked to N bits; `b` is the emitted bit.
- One word is `DATA_W` consecutive steps. The first emitted bit goes to `out_data[DATA_W-1]`.
- On `seed_load`:
  - `lfsr <=` the low N bits of `seed`. If those bits are all zero, load all ones, so the LFSR can never lock up.
  - A reserved mode latches as PRBS7 and sets `mode_err`. A later legal load clears `mode_err`.
- States:
  - **IDLE**: no valid word. Moves to RUN when a word is loaded.
  - **RUN**: a word is held. Returns to IDLE when that word is accepted and `enable` is low.
- Word load condition: `enable && (!out_valid || out_ready) && !seed_load`. On a load:
  - `out_data` takes the next word; `out_valid` is set to 1.
  - `lfsr` advances `DATA_W` steps.
- Stall (`out_valid && !out_ready`): `out_data`, `out_valid` and `lfsr` are held. A held word is never retracted by `enable` going low.
- Error injection:
  - `inj_err` sets a pending flag.
  - The next loaded word has `out_data[DATA_W-1]` inverted. The LFSR itself is unaffected.
  - The flag clears on that load. Multiple pulses before the load collapse into one.
- `word_cnt` increments on each cycle with `out_valid && out_ready`.

## Timing
- Reset values: `lfsr` = all ones, latched mode = PRBS7, state = IDLE, `out_valid` = 0, `out_data` = 0, `word_cnt` = 0, `mode_err` = 0, pending error = 0.
- Latency: `enable` high at edge k gives `out_valid` = 1 after edge k. With `out_ready` held high, one word is produced per cycle with no bubbles.
- `seed_load` at edge k:
  - `out_valid` = 0 after edge k; any held word is discarded and not counted, even if `out_ready` was high.
  - The first word from the new seed appears after edge k+1, if `enable` is high.
- A `seed_load` during a reset assertion is ignored.
- A reset asserted mid-stream clears the state immediately and asynchronously; nothing is emitted until `enable` is seen after reset release.

## Structure
- Package `prbs_pkg` holds:
  - the `prbs_mode_e` enum (3 bits);
  - per-mode `PRBS_LEN` and `PRBS_TAP` constant functions or arrays;
  - the reserved-mode check.
- Sub-module `prbs_step`: purely combinational. It unrolls `DATA_W` LFSR steps. Inputs are `lfsr`, N and M; outputs are the next `lfsr` and the word. The top level holds the FSM, handshake, injection and counter.

## Test plan
- Reset, then `DATA_W`=8, seed_load with mode 0 and seed 0x7F, `enable`=1, `out_ready`=1: words 0x02 then 0x0C; `word_cnt` = 2.
- Same setup with `out_ready`=0 for 3 cycles: 0x02 is held stable for 3 cycles, then 0x0C follows; no words are skipped or duplicated.
- seed 0 with mode 4: behaves exactly as seed 0x7FFFFFFF. Run 2^31−1 steps, or check against a reference model over 10k words: no all-zero state occurs.
- `inj_err` pulse during a stall on 0x02: the next word is 0x8C, the one after it is unaltered, and the sequence continues.
- seed_load with mode 6: `mode_err` = 1 and output matches PRBS7. A later load with mode 1 clears `mode_err`. seed_load coinciding with a handshake: that word is not counted.
- Reset mid-run: `out_valid` drops asynchronously, `word_cnt` = 0, and after release the stream restarts from the all-ones PRBS7 state.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared types and per-polynomial constants for the multi-polynomial PRBS generator.
// Mode decoding lives here so the top level and the step unroller agree on lengths and taps.
package prbs_pkg;

    localparam int LFSR_W = 31;

    typedef enum logic [2:0] {
        PRBS7  = 3'd0,
        PRBS9  = 3'd1,
        PRBS15 = 3'd2,
        PRBS23 = 3'd3,
        PRBS31 = 3'd4
    } prbs_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } prbs_state_e;

    function automatic logic [4:0] prbs_len(input prbs_mode_e m);
        case (m)
            PRBS9:   return 5'd9;
            PRBS15:  return 5'd15;
            PRBS23:  return 5'd23;
            PRBS31:  return 5'd31;
            default: return 5'd7;
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap(input prbs_mode_e m);
        case (m)
            PRBS9:   return 5'd5;
            PRBS15:  return 5'd14;
            PRBS23:  return 5'd18;
            PRBS31:  return 5'd28;
            default: return 5'd6;
        endcase
    endfunction

    function automatic logic mode_reserved(input logic [2:0] m);
        return m > 3'd4;
    endfunction

    // Ones in the low len bits; used both to truncate the shift and as the lock-up-free seed.
    function automatic logic [LFSR_W-1:0] len_mask(input logic [4:0] len);
        logic [LFSR_W-1:0] m;
        for (int i = 0; i < LFSR_W; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

endpackage

// File: rtl/prbs_step.sv
// Combinational unroll of DATA_W Fibonacci LFSR steps for a run-time selected length and tap.
// The first generated bit lands in the word MSB.
module prbs_step
    import prbs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [LFSR_W-1:0] lfsr,
    input  logic [4:0]        len,
    input  logic [4:0]        tap,
    output logic [LFSR_W-1:0] next_lfsr,
    output logic [DATA_W-1:0] word
);

    logic [LFSR_W-1:0] mask;

    assign mask = len_mask(len);

    always_comb begin
        logic [LFSR_W-1:0] s;
        logic              b;
        s    = lfsr;
        b    = 1'b0;
        word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            b                   = s[len - 5'd1] ^ s[tap - 5'd1];
            word[DATA_W-1-i]    = b;
            s                   = {s[LFSR_W-2:0], b} & mask;
        end
        next_lfsr = s;
    end

endmodule

// File: rtl/prbs_gen.sv
// PRBS7/9/15/23/31 word generator with valid/ready back-pressure, single-bit error
// injection on the next loaded word, and an accepted-word counter.
module prbs_gen
    import prbs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        mode,
    input  logic [30:0]       seed,
    input  logic              seed_load,
    input  logic              enable,
    input  logic              inj_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              mode_err,
    output logic [CNT_W-1:0]  word_cnt
);

    prbs_state_e       state, state_next;
    prbs_mode_e        mode_q;
    prbs_mode_e        load_mode;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] step_lfsr;
    logic [LFSR_W-1:0] load_mask;
    logic [LFSR_W-1:0] seed_masked;
    logic [LFSR_W-1:0] seeded;
    logic [DATA_W-1:0] step_word;
    logic [DATA_W-1:0] inj_mask;
    logic              inj_pend;
    logic              load;
    logic              accept;

    assign out_valid = (state == RUN);
    assign load      = enable && (!out_valid || out_ready) && !seed_load;
    assign accept    = out_valid && out_ready && !seed_load;

    prbs_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .lfsr     (lfsr),
        .len      (prbs_len(mode_q)),
        .tap      (prbs_tap(mode_q)),
        .next_lfsr(step_lfsr),
        .word     (step_word)
    );

    // Reserved modes fall back to PRBS7; an all-zero seed becomes all ones to avoid lock-up.
    always_comb begin
        load_mode   = mode_reserved(mode) ? PRBS7 : prbs_mode_e'(mode);
        load_mask   = len_mask(prbs_len(load_mode));
        seed_masked = seed & load_mask;
        seeded      = (seed_masked == '0) ? load_mask : seed_masked;
        inj_mask    = '0;
        inj_mask[DATA_W-1] = inj_pend;
    end

    always_comb begin
        state_next = state;
        if (seed_load) begin
            state_next = IDLE;
        end else if (load) begin
            state_next = RUN;
        end else if (out_valid && out_ready) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr     <= '1;
            mode_q   <= PRBS7;
            mode_err <= 1'b0;
            out_data <= '0;
            inj_pend <= 1'b0;
        end else begin
            if (seed_load) begin
                mode_q   <= load_mode;
                mode_err <= mode_reserved(mode);
                lfsr     <= seeded;
            end else if (load) begin
                lfsr     <= step_lfsr;
                out_data <= step_word ^ inj_mask;
            end
            // A pulse in the same cycle as a load stays pending for the following word.
            inj_pend <= (inj_pend && !load) || inj_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_prbs_gen.sv
// Self-checking bench for prbs_gen: directed vector table, reset/seed corner sequences,
// and randomized traffic compared against an arithmetic sequence model.
module tb_prbs_gen;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        mode;
    logic [30:0]       seed;
    logic              seed_load;
    logic              enable;
    logic              inj_err;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              mode_err;
    logic [CNT_W-1:0]  word_cnt;

    int vectors     = 0;
    int miscompares = 0;

    prbs_gen #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .seed     (seed),
        .seed_load(seed_load),
        .enable   (enable),
        .inj_err  (inj_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .mode_err (mode_err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: sequence state as a plain integer plus the stream handshake rules.
    longint            m_state;
    int                m_n, m_m;
    bit                m_merr, m_valid, m_pend;
    bit [DATA_W-1:0]   m_data;
    bit [CNT_W-1:0]    m_cnt;

    function automatic void model_reset();
        m_state = 64'h7FFF_FFFF;
        m_n     = 7;
        m_m     = 6;
        m_merr  = 1'b0;
        m_valid = 1'b0;
        m_pend  = 1'b0;
        m_data  = '0;
        m_cnt   = '0;
    endfunction

    function automatic void model_edge(input bit sl, input bit [2:0] md, input bit [30:0] sd,
                                       input bit en, input bit inj, input bit rdy);
        bit     ld;
        longint mask;
        longint b;
        ld = en && (!m_valid || rdy) && !sl;
        if (m_valid && rdy && !sl) m_cnt = m_cnt + 1'b1;
        if (sl) begin
            case (md)
                3'd1:    begin m_n = 9;  m_m = 5;  end
                3'd2:    begin m_n = 15; m_m = 14; end
                3'd3:    begin m_n = 23; m_m = 18; end
                3'd4:    begin m_n = 31; m_m = 28; end
                default: begin m_n = 7;  m_m = 6;  end
            endcase
            m_merr  = (md > 3'd4);
            mask    = (64'd1 << m_n) - 1;
            m_state = longint'(sd) & mask;
            if (m_state == 0) m_state = mask;
            m_valid = 1'b0;
        end else if (ld) begin
            mask = (64'd1 << m_n) - 1;
            for (int i = 0; i < DATA_W; i++) begin
                b = ((m_state >> (m_n - 1)) ^ (m_state >> (m_m - 1))) & 1;
                m_data[DATA_W-1-i] = b[0];
                m_state = ((m_state << 1) | b) & mask;
            end
            if (m_pend) m_data[DATA_W-1] = ~m_data[DATA_W-1];
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_pend = (m_pend && !ld) || inj;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs; the model sees the same inputs at the same edge.
    task automatic applyStimulus(input bit sl, input bit [2:0] md, input bit [30:0] sd,
                                 input bit en, input bit inj, input bit rdy);
        seed_load = sl;
        mode      = md;
        seed      = sd;
        enable    = en;
        inj_err   = inj;
        out_ready = rdy;
        model_edge(sl, md, sd, en, inj, rdy);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit        sl;
        bit [2:0]  md;
        bit [30:0] sd;
        bit        en;
        bit        inj;
        bit        rdy;
        bit        ev;
        bit [7:0]  ed;
        int        ec;
        bit        emerr;
    } vec_t;

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{1, 0, 31'h7F,  1, 0, 1, 0, 8'h00, 0, 0};
        vecs[1]  = '{0, 0, 31'h0,   1, 0, 1, 1, 8'h02, 0, 0};
        vecs[2]  = '{0, 0, 31'h0,   1, 0, 1, 1, 8'h0C, 1, 0};
        vecs[3]  = '{0, 0, 31'h0,   0, 0, 1, 0, 8'h00, 2, 0};
        vecs[4]  = '{1, 0, 31'h7F,  1, 0, 0, 0, 8'h00, 2, 0};
        vecs[5]  = '{0, 0, 31'h0,   1, 0, 0, 1, 8'h02, 2, 0};
        vecs[6]  = '{0, 0, 31'h0,   1, 0, 0, 1, 8'h02, 2, 0};
        vecs[7]  = '{0, 0, 31'h0,   1, 1, 0, 1, 8'h02, 2, 0};
        vecs[8]  = '{0, 0, 31'h0,   1, 0, 1, 1, 8'h8C, 3, 0};
        vecs[9]  = '{0, 0, 31'h0,   1, 0, 1, 1, 8'h28, 4, 0};
        vecs[10] = '{0, 0, 31'h0,   0, 0, 1, 0, 8'h00, 5, 0};
        vecs[11] = '{1, 6, 31'h7F,  0, 0, 0, 0, 8'h00, 5, 1};
        vecs[12] = '{0, 0, 31'h0,   1, 0, 1, 1, 8'h02, 5, 1};
        vecs[13] = '{1, 1, 31'h1FF, 0, 0, 1, 0, 8'h00, 5, 0};
        vecs[14] = '{0, 0, 31'h0,   1, 0, 1, 1, 8'h07, 5, 0};
        vecs[15] = '{0, 0, 31'h0,   0, 0, 1, 0, 8'h00, 6, 0};
        vecs[16] = '{1, 0, 31'h0,   1, 0, 1, 0, 8'h00, 6, 0};
        vecs[17] = '{0, 0, 31'h0,   1, 0, 1, 1, 8'h02, 6, 0};
        vecs[18] = '{0, 0, 31'h0,   0, 0, 1, 0, 8'h00, 7, 0};

        reset     = 1'b1;
        seed_load = 1'b0;
        mode      = 3'd0;
        seed      = '0;
        enable    = 1'b0;
        inj_err   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset out_data",  64'(out_data),  64'd0);
        checkOutput("reset word_cnt",  64'(word_cnt),  64'd0);
        checkOutput("reset mode_err",  64'(mode_err),  64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].sl, vecs[i].md, vecs[i].sd, vecs[i].en, vecs[i].inj, vecs[i].rdy);
            checkOutput($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            if (vecs[i].ev) checkOutput($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vecs[i].ed));
            checkOutput($sformatf("vec%0d word_cnt", i), 64'(word_cnt), 64'(vecs[i].ec));
            checkOutput($sformatf("vec%0d mode_err", i), 64'(mode_err), 64'(vecs[i].emerr));
        end

        // Reset mid-stream: outputs clear without waiting for a clock edge.
        repeat (3) applyStimulus(0, 0, 0, 1, 0, 1);
        #3;
        reset     = 1'b1;
        seed_load = 1'b1;
        mode      = 3'd4;
        seed      = 31'h5;
        #1;
        checkOutput("async reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("async reset word_cnt",  64'(word_cnt),  64'd0);
        model_reset();
        @(posedge clk);
        #1;
        checkOutput("seed_load under reset", 64'(out_valid), 64'd0);
        seed_load = 1'b0;
        enable    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("restart out_valid", 64'(out_valid), 64'd1);
        checkOutput("restart word0",     64'(out_data),  64'h02);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkOutput("restart word1",     64'(out_data),  64'h0C);
        checkOutput("restart word_cnt",  64'(word_cnt),  64'd1);

        // PRBS31 zero seed must behave as the all-ones seed: model loads 0x7FFFFFFF.
        seed_load = 1'b1;
        mode      = 3'd4;
        seed      = 31'h0;
        enable    = 1'b1;
        inj_err   = 1'b0;
        out_ready = 1'b1;
        model_edge(1, 3'd4, 31'h7FFF_FFFF, 1, 0, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 1);
            checkOutput($sformatf("prbs31 word%0d", i), 64'(out_data), 64'(m_data));
        end
        checkOutput("prbs31 word_cnt", 64'(word_cnt), 64'(m_cnt));

        // Randomized traffic across all modes, with stalls, injections and reloads.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 49) == 0, 3'($urandom_range(0, 7)), 31'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom));
            checkOutput($sformatf("rand%0d out_valid", i), 64'(out_valid), 64'(m_valid));
            if (m_valid) checkOutput($sformatf("rand%0d out_data", i), 64'(out_data), 64'(m_data));
            checkOutput($sformatf("rand%0d word_cnt", i), 64'(word_cnt), 64'(m_cnt));
            checkOutput($sformatf("rand%0d mode_err", i), 64'(mode_err), 64'(m_merr));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
